// File: rtl/sniff_pkg.sv
// Shared constants and types for the MAC-to-sniffer store-and-forward frame buffer.
package sniff_pkg;

  localparam int unsigned DATAWIDTH       = 32;
  localparam int unsigned MAC_EMPTYW      = 2;
  localparam int unsigned ERRW            = 6;
  localparam int unsigned ADDRW           = 9;
  localparam int unsigned CNTW            = 16;
  localparam int unsigned MAX_FRAME_WORDS = 380;

  typedef enum logic [1:0] {
    W_IDLE,
    W_STORE,
    W_DISCARD
  } wr_state_t;

endpackage

// File: rtl/sniff_frame_ram.sv
// Simple dual-port frame RAM with a registered read port (1-cycle read latency).
module sniff_frame_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 35
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/mac_frame_buffer.sv
// Store-and-forward buffer: writes whole MAC frames, commits clean ones on eop,
// and replays committed words to the sniffer through a registered 2-entry skid.
module mac_frame_buffer
  import sniff_pkg::*;
#(
  parameter int unsigned DATAWIDTH       = sniff_pkg::DATAWIDTH,
  parameter int unsigned ADDRW           = sniff_pkg::ADDRW,
  parameter int unsigned MAX_FRAME_WORDS = sniff_pkg::MAX_FRAME_WORDS,
  parameter int unsigned ERRW            = sniff_pkg::ERRW,
  parameter int unsigned CNTW            = sniff_pkg::CNTW
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATAWIDTH-1:0]  snk_data,
  input  logic                  snk_valid,
  input  logic                  snk_sop,
  input  logic                  snk_eop,
  input  logic [MAC_EMPTYW-1:0] snk_empty,
  input  logic [ERRW-1:0]       snk_error,
  output logic                  snk_ready,
  output logic [DATAWIDTH-1:0]  src_data,
  output logic                  src_valid,
  output logic                  src_sop,
  output logic                  src_eop,
  output logic [MAC_EMPTYW-1:0] src_empty,
  input  logic                  src_ready,
  output logic [CNTW-1:0]       frames_fwd,
  output logic [CNTW-1:0]       frames_drop,
  output logic [ADDRW:0]        buf_level
);

  localparam int unsigned PW = ADDRW + 1;
  localparam int unsigned TW = DATAWIDTH + MAC_EMPTYW + 1;  // {eop, empty, data}
  localparam logic [PW-1:0] Depth   = PW'(2**ADDRW);
  localparam logic [PW-1:0] MaxWords = PW'(MAX_FRAME_WORDS);

  wr_state_t     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wcnt_q, wcnt_d, free_commit;
  logic [CNTW-1:0] fwd_q, fwd_d, drop_q, drop_d;
  logic          ready_q, start, ram_we, rd_en, pop;
  logic [ADDRW-1:0] ram_waddr;
  logic [TW-1:0] ram_rd_data;

  logic              rd_pend_q, head_q, next_sop_q;
  logic [1:0]        skid_cnt_q;
  logic [TW:0]       skid_q [2];
  logic [2:0]        occ;

  // Space check is made against the committed boundary since a new frame always starts there.
  assign free_commit = Depth - (commit_ptr_q - rd_ptr_q);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wcnt_d       = wcnt_q;
    fwd_d        = fwd_q;
    drop_d       = drop_q;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q[ADDRW-1:0];
    start        = 1'b0;
    if (snk_valid) begin
      unique case (state_q)
        W_IDLE: start = snk_sop;
        W_STORE: begin
          if (snk_sop) begin
            drop_d = drop_d + CNTW'(1);
            start  = 1'b1;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            wcnt_d   = wcnt_q + PW'(1);
            if (snk_eop) begin
              if (snk_error != '0 || wcnt_d > MaxWords) begin
                wr_ptr_d = commit_ptr_q;
                drop_d   = drop_d + CNTW'(1);
              end else begin
                commit_ptr_d = wr_ptr_q + PW'(1);
                fwd_d        = fwd_d + CNTW'(1);
              end
              state_d = W_IDLE;
            end else if (wcnt_d == MaxWords) begin
              wr_ptr_d = commit_ptr_q;
              drop_d   = drop_d + CNTW'(1);
              state_d  = W_DISCARD;
            end
          end
        end
        W_DISCARD: if (snk_eop) state_d = W_IDLE;
        default: state_d = W_IDLE;
      endcase
    end
    // A sop (fresh or after an aborted frame) always begins at commit_ptr.
    if (start) begin
      if (free_commit >= MaxWords) begin
        ram_we    = 1'b1;
        ram_waddr = commit_ptr_q[ADDRW-1:0];
        wcnt_d    = PW'(1);
        if (!snk_eop) begin
          wr_ptr_d = commit_ptr_q + PW'(1);
          state_d  = W_STORE;
        end else if (snk_error != '0) begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = drop_d + CNTW'(1);
          state_d  = W_IDLE;
        end else begin
          wr_ptr_d     = commit_ptr_q + PW'(1);
          commit_ptr_d = commit_ptr_q + PW'(1);
          fwd_d        = fwd_d + CNTW'(1);
          state_d      = W_IDLE;
        end
      end else begin
        wr_ptr_d = commit_ptr_q;
        drop_d   = drop_d + CNTW'(1);
        state_d  = snk_eop ? W_IDLE : W_DISCARD;
      end
    end
  end

  // Issue a RAM read only if the skid can absorb it, counting the read already in flight.
  assign pop      = src_valid & src_ready;
  assign occ      = {1'b0, skid_cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign rd_en    = (rd_ptr_q != commit_ptr_q) && (occ < 3'd2);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_en);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      wcnt_q       <= '0;
      fwd_q        <= '0;
      drop_q       <= '0;
      ready_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      head_q       <= 1'b0;
      next_sop_q   <= 1'b1;
      skid_cnt_q   <= '0;
      for (int i = 0; i < 2; i++) skid_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wcnt_q       <= wcnt_d;
      fwd_q        <= fwd_d;
      drop_q       <= drop_d;
      ready_q      <= 1'b1;
      rd_pend_q    <= rd_en;
      if (rd_pend_q) begin
        skid_q[head_q ^ skid_cnt_q[0]] <= {next_sop_q, ram_rd_data};
        next_sop_q <= ram_rd_data[TW-1];
      end
      if (pop) head_q <= ~head_q;
      skid_cnt_q <= skid_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end
  end

  sniff_frame_ram #(
    .AW(ADDRW),
    .DW(TW)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (ram_we),
    .wr_addr_i(ram_waddr),
    .wr_data_i({snk_eop, snk_empty, snk_data}),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_ptr_q[ADDRW-1:0]),
    .rd_data_o(ram_rd_data)
  );

  assign snk_ready   = ready_q;
  assign src_valid   = (skid_cnt_q != 2'd0);
  assign src_sop     = skid_q[head_q][TW];
  assign src_eop     = skid_q[head_q][TW-1];
  assign src_empty   = skid_q[head_q][DATAWIDTH+MAC_EMPTYW-1:DATAWIDTH];
  assign src_data    = skid_q[head_q][DATAWIDTH-1:0];
  assign frames_fwd  = fwd_q;
  assign frames_drop = drop_q;
  assign buf_level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_mac_frame_buffer.sv
// Self-checking bench: frame table, directed corner sequences and random traffic
// compared against a frame-level queue model of the buffer.
module tb_mac_frame_buffer;

  localparam int DEPTH = 512;
  localparam int MAXW  = 380;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] snk_data = '0;
  logic        snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
  logic [1:0]  snk_empty = '0;
  logic [5:0]  snk_error = '0;
  logic        snk_ready;
  logic [31:0] src_data;
  logic        src_valid, src_sop, src_eop;
  logic [1:0]  src_empty;
  logic        src_ready;
  logic [15:0] frames_fwd, frames_drop;
  logic [9:0]  buf_level;

  always #5 clk = ~clk;

  mac_frame_buffer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .snk_data   (snk_data),
    .snk_valid  (snk_valid),
    .snk_sop    (snk_sop),
    .snk_eop    (snk_eop),
    .snk_empty  (snk_empty),
    .snk_error  (snk_error),
    .snk_ready  (snk_ready),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_empty  (src_empty),
    .src_ready  (src_ready),
    .frames_fwd (frames_fwd),
    .frames_drop(frames_drop),
    .buf_level  (buf_level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int ready_mode = 0;  // 0 always, 1 never, 2 toggle, 3 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference model: words of a frame are collected and released whole.
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } oword_t;

  oword_t exp_q[$];
  oword_t cur_q[$];
  bit     m_in, m_disc;
  int     m_fwd, m_drop;

  function automatic void model_reset();
    exp_q.delete();
    cur_q.delete();
    m_in = 0;
    m_disc = 0;
    m_fwd = 0;
    m_drop = 0;
  endfunction

  function automatic void model_word(input logic [31:0] d, input bit sop, input bit eop,
                                     input logic [1:0] emp, input logic [5:0] err);
    oword_t w;
    w.data = d;
    w.sop = 1'b0;
    w.eop = eop;
    w.empty = eop ? emp : 2'b00;
    if (m_disc) begin
      if (eop) m_disc = 0;
      return;
    end
    if (sop) begin
      if (m_in) begin
        m_drop++;
        cur_q.delete();
        m_in = 0;
      end
      if (DEPTH - exp_q.size() < MAXW) begin
        m_drop++;
        m_disc = !eop;
        return;
      end
      m_in = 1;
      w.sop = 1'b1;
    end else if (!m_in) begin
      return;
    end
    cur_q.push_back(w);
    if (eop) begin
      if (err != 0) m_drop++;
      else begin
        m_fwd++;
        foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
      end
      cur_q.delete();
      m_in = 0;
    end else if (cur_q.size() == MAXW) begin
      m_drop++;
      cur_q.delete();
      m_in = 0;
      m_disc = 1;
    end
  endfunction

  task automatic drive(input logic [31:0] d, input bit sop, input bit eop,
                       input logic [1:0] emp, input logic [5:0] err);
    snk_valid = 1'b1;
    snk_data  = d;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_empty = emp;
    snk_error = err;
    model_word(d, sop, eop, emp, err);
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_error = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int id, input int nw, input logic [1:0] emp,
                            input logic [5:0] err);
    for (int w = 0; w < nw; w++)
      drive({8'(id), 24'(w)}, w == 0, w == nw - 1, emp, (w == nw - 1) ? err : 6'd0);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      idle(1);
      t++;
    end
    idle(6);
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_fwd"}, 64'(frames_fwd), 64'(m_fwd[15:0]));
    check({name, "_drop"}, 64'(frames_drop), 64'(m_drop[15:0]));
    check({name, "_level"}, 64'(buf_level), 64'd0);
  endtask

  initial begin
    src_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: src_ready = 1'b1;
        1: src_ready = 1'b0;
        2: src_ready = ~src_ready;
        default: src_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Output scoreboard plus hold-while-stalled check.
  initial begin
    logic [36:0] prev_out;
    bit stall_prev;
    oword_t e;
    stall_prev = 0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) stall_prev = 0;
      else begin
        if (stall_prev)
          check("stall_hold", {src_valid, src_data, src_sop, src_eop, src_empty}, prev_out);
        if (src_valid && src_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_extra: got word %0h, expected no word", src_data);
          end else begin
            e = exp_q.pop_front();
            check("out_word", {src_data, src_sop, src_eop, src_eop ? src_empty : 2'b00}, e);
          end
        end
        stall_prev = src_valid && !src_ready;
        prev_out = {src_valid, src_data, src_sop, src_eop, src_empty};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         nwords;
    logic [1:0] empty;
    logic [5:0] err;
    int         exp_out;
    int         exp_fwd;
    int         exp_drop;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int out0, fwd0, drop0, t;
    vecs[0] = '{4,   2'd2, 6'h00, 4,   1, 0};
    vecs[1] = '{3,   2'd1, 6'h01, 0,   0, 1};
    vecs[2] = '{2,   2'd0, 6'h00, 2,   1, 0};
    vecs[3] = '{400, 2'd3, 6'h00, 0,   0, 1};
    vecs[4] = '{5,   2'd1, 6'h00, 5,   1, 0};
    vecs[5] = '{1,   2'd3, 6'h00, 1,   1, 0};
    vecs[6] = '{380, 2'd0, 6'h00, 380, 1, 0};
    vecs[7] = '{1,   2'd0, 6'h3f, 0,   0, 1};
    model_reset();

    #2;
    check("rst_snk_ready", 64'(snk_ready), 64'd0);
    check("rst_src_valid", 64'(src_valid), 64'd0);
    check("rst_counters", {frames_fwd, frames_drop, 6'(buf_level)}, 64'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(2);
    check("ready_after_rst", 64'(snk_ready), 64'd1);

    ready_mode = 0;
    foreach (vecs[i]) begin
      out0 = n_out;
      fwd0 = int'(frames_fwd);
      drop0 = int'(frames_drop);
      send_frame(i, vecs[i].nwords, vecs[i].empty, vecs[i].err);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_nout", i), 64'(n_out - out0), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d_dfwd", i), 64'(int'(frames_fwd) - fwd0), 64'(vecs[i].exp_fwd));
      check($sformatf("vec%0d_ddrop", i), 64'(int'(frames_drop) - drop0), 64'(vecs[i].exp_drop));
    end

    // Two max frames while stalled: second cannot fit and is dropped.
    ready_mode = 1;
    idle(2);
    out0 = n_out;
    drop0 = int'(frames_drop);
    send_frame(20, 380, 2'd1, 6'd0);
    send_frame(21, 380, 2'd2, 6'd0);
    idle(4);
    check("full_valid_stalled", 64'(src_valid), 64'd1);
    check("full_ddrop", 64'(int'(frames_drop) - drop0), 64'd1);
    ready_mode = 0;
    drain("full");
    check("full_nout", 64'(n_out - out0), 64'd380);

    // Ready toggling every cycle.
    ready_mode = 2;
    out0 = n_out;
    send_frame(30, 10, 2'd3, 6'd0);
    drain("toggle");
    check("toggle_nout", 64'(n_out - out0), 64'd10);

    // Missing eop: new sop aborts the open frame; sop+eop with error drops twice.
    ready_mode = 0;
    drop0 = int'(frames_drop);
    drive(32'hA0, 1, 0, 0, 0);
    drive(32'hA1, 0, 0, 0, 0);
    send_frame(40, 2, 2'd1, 6'd0);
    drive(32'hB0, 1, 0, 0, 0);
    drive(32'hB1, 1, 1, 0, 6'h04);
    drain("abort");
    check("abort_ddrop", 64'(int'(frames_drop) - drop0), 64'd3);

    // Random traffic with random back-pressure.
    ready_mode = 3;
    for (int f = 0; f < 150; f++) begin
      automatic int len = $urandom_range(1, 12);
      automatic bit trunc = (f < 149) && ($urandom_range(0, 9) == 0);
      automatic logic [5:0] err = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      automatic logic [1:0] emp = 2'($urandom_range(0, 3));
      if (f < 149 && $urandom_range(0, 7) == 0) drive($urandom, 0, 1'($urandom_range(0, 1)), 0, 0);
      for (int w = 0; w < len; w++) begin
        automatic bit last = (w == len - 1) && !trunc;
        drive($urandom, w == 0, last, emp, last ? err : 6'd0);
        if ($urandom_range(0, 1) == 0) idle(1);
      end
    end
    drain("rand");

    // Reset while a frame is partly written and another is waiting to replay.
    ready_mode = 1;
    send_frame(50, 5, 2'd0, 6'd0);
    drive(32'hC0, 1, 0, 0, 0);
    drive(32'hC1, 0, 0, 0, 0);
    idle(3);
    check("pre_rst_valid", 64'(src_valid), 64'd1);
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", 64'(src_valid), 64'd0);
    check("mid_rst_data", {src_data, src_sop, src_eop, src_empty}, 64'd0);
    check("mid_rst_cnt", {frames_fwd, frames_drop, buf_level}, 64'd0);
    check("mid_rst_ready", 64'(snk_ready), 64'd0);
    idle(2);
    n_rst = 1'b1;
    ready_mode = 0;
    idle(2);
    drive(32'h5EED_0001, 1, 1, 2'd3, 0);
    t = 0;
    while (!src_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("post_rst_soeop", {src_valid, src_sop, src_eop, src_data}, {3'b111, 32'h5EED_0001});
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
